post_st_drain: RTL and testbench

//  Drain stage directly downstream of the post-store FIFO: pops resolved store packets from the FIFO head,

---
 rtl/post_st_drain_pkg.sv | 28 ++
 rtl/post_st_drain_st_align.sv | 52 +++++
 rtl/post_st_drain.sv | 147 ++++++++++++++
 tb/tb_post_st_drain.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/post_st_drain_pkg.sv
// post_st_drain_pkg
//   Types shared by the post-store drain stage and its alignment helper.
//   mem_pkt_t         : resolved store packet as presented at the FIFO head
//   st_funct3_e       : store widths encoded in funct3 (SB/SH/SW)
//   st_drain_state_t  : drain FSM states
package post_st_drain_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [3:0]  bmask;
  } mem_pkt_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } st_funct3_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } st_drain_state_t;

  localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/post_st_drain_st_align.sv
// st_align
//   Purely combinational store alignment. Turns a store width plus the low
//   address bits into a byte write mask and lane-replicated write data.
//   Ports:
//     funct3_i    store width (SB/SH/SW); anything else is undefined
//     byte_off_i  addr[1:0] of the store
//     wdata_i     unaligned store data (value in the low lanes)
//     wmask_o     byte write enables
//     wdata_o     write data replicated into every lane of its width
//     valid_o     funct3 is a defined store width
module st_align
  import post_st_drain_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        valid_o
);

  // Replicating data across lanes lets the memory take whichever lane the
  // mask enables; for halfwords addr[0] is ignored on purpose.
  always_comb begin
    wmask_o = 4'b0000;
    wdata_o = 32'h0;
    valid_o = 1'b0;
    case (funct3_i)
      F3_SB: begin
        wmask_o = 4'b0001 << byte_off_i;
        wdata_o = {4{wdata_i[7:0]}};
        valid_o = 1'b1;
      end
      F3_SH: begin
        wmask_o = byte_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        valid_o = 1'b1;
      end
      F3_SW: begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        valid_o = 1'b1;
      end
      default: begin
        wmask_o = 4'b0000;
        wdata_o = 32'h0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/post_st_drain.sv
// post_st_drain
//   Drains resolved stores from the post-store FIFO head onto the shared
//   data-memory port, one word-aligned write outstanding at a time, sharing
//   the port with the load unit. A starvation counter gives a waiting store
//   priority after STARVE_LIMIT consecutive losses to ld_req.
//   Ports:
//     clk, rst        clock; synchronous active-high reset
//     fifo_out        FIFO head packet
//     fifo_empty      FIFO has no valid head
//     fifo_ren        pop FIFO head this cycle (combinational)
//     ld_req/ld_busy  load unit request / load outstanding
//     ld_gnt          load may issue this cycle (combinational)
//     dmem_st_sel     this block owns the dmem port
//     dmem_addr/wmask/wdata  registered write request
//     dmem_resp       one-cycle write-complete pulse
//     st_busy         write in flight
//   Optional: define POST_ST_DRAIN_PERF_EN to add perf_st_cnt and
//   perf_stall_cnt performance counters.
module post_st_drain
  import post_st_drain_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_pkt_t    fifo_out,
  input  logic        fifo_empty,
  output logic        fifo_ren,
  input  logic        ld_req,
  input  logic        ld_busy,
  output logic        ld_gnt,
  output logic        dmem_st_sel,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  output logic        st_busy
`ifdef POST_ST_DRAIN_PERF_EN
  ,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  st_drain_state_t state_q;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      wmask_q;

  logic        in_idle, drainable, store_win;
  logic [3:0]  align_wmask;
  logic [31:0] align_wdata;
  logic        align_valid;

  st_align u_align (
    .funct3_i   (fifo_out.funct3),
    .byte_off_i (fifo_out.addr[1:0]),
    .wdata_i    (fifo_out.wdata),
    .wmask_o    (align_wmask),
    .wdata_o    (align_wdata),
    .valid_o    (align_valid)
  );

  // A head with any bmask bit set is still speculative and must wait.
  // ld_busy always blocks a store start; ld_req only until the guard trips.
  assign in_idle   = (state_q == ST_IDLE);
  assign drainable = !fifo_empty && (fifo_out.bmask == '0);
  assign store_win = drainable && !ld_busy && (!ld_req || starve_cnt_q == LIMIT);
  assign fifo_ren  = !rst && in_idle && store_win;
  assign ld_gnt    = !rst && in_idle && ld_req && !store_win;

  assign dmem_st_sel = (state_q == ST_WRITE);
  assign st_busy     = (state_q == ST_WRITE);
  assign dmem_addr   = addr_q;
  assign dmem_wmask  = wmask_q;
  assign dmem_wdata  = wdata_q;

  // Starvation counter: counts consecutive losses of a drainable head to a
  // load, saturating at the limit; any pop or non-drainable head clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!drainable) begin
      starve_cnt_d = '0;
    end else if (in_idle) begin
      if (store_win) begin
        starve_cnt_d = '0;
      end else if (ld_req && starve_cnt_q != LIMIT) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
    end
  end

  // Drain FSM. The aligned request is latched on the pop so the dmem port
  // sees it the following cycle and holds it until the write completes.
  // An undefined funct3 is still popped but never turns into a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (fifo_ren && align_valid) begin
            addr_q  <= {fifo_out.addr[31:2], 2'b00};
            wmask_q <= align_wmask;
            wdata_q <= align_wdata;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (dmem_resp) begin
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef POST_ST_DRAIN_PERF_EN
  // Completed writes and idle cycles where a ready store was held back.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_st_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (!in_idle && dmem_resp) begin
        perf_st_cnt <= perf_st_cnt + 32'd1;
      end
      if (in_idle && drainable && !store_win) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_post_st_drain.sv
// tb_post_st_drain
//   Self-checking bench for post_st_drain. A queue stands in for the FIFO,
//   and a behavioural model derived from the drain rules predicts every
//   output each cycle. Directed scenarios are followed by a randomized run.
module tb_post_st_drain;
  import post_st_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  mem_pkt_t    fifo_out;
  logic        fifo_empty;
  logic        fifo_ren;
  logic        ld_req;
  logic        ld_busy;
  logic        ld_gnt;
  logic        dmem_st_sel;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic        st_busy;
`ifdef POST_ST_DRAIN_PERF_EN
  logic [31:0] perf_st_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_pkt_t fifoQ[$];

  bit          mWriting;
  logic [31:0] mAddr, mData;
  logic [3:0]  mMask;
  int          mStarve;
  int          mPerfSt, mPerfStall;
  bit          checkEn;
  int          obsGnt;
  bit          obsRen;

  post_st_drain dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_out    (fifo_out),
    .fifo_empty  (fifo_empty),
    .fifo_ren    (fifo_ren),
    .ld_req      (ld_req),
    .ld_busy     (ld_busy),
    .ld_gnt      (ld_gnt),
    .dmem_st_sel (dmem_st_sel),
    .dmem_addr   (dmem_addr),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .dmem_resp   (dmem_resp),
    .st_busy     (st_busy)
`ifdef POST_ST_DRAIN_PERF_EN
    ,
    .perf_st_cnt    (perf_st_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference alignment from store size and byte offset arithmetic.
  task automatic refAlign(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output bit valid,
                          output logic [3:0] mask, output logic [31:0] data);
    int size;
    int off;
    valid = 1'b1;
    case (f3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      default: size = 0;
    endcase
    if (size == 0) begin
      valid = 1'b0;
      mask  = 4'h0;
      data  = 32'h0;
    end else begin
      off  = (int'(addr % 4) / size) * size;
      mask = 4'(((1 << size) - 1) << off);
      if (size == 1)      data = (wd & 32'hFF) * 32'h0101_0101;
      else if (size == 2) data = (wd & 32'hFFFF) * 32'h0001_0001;
      else                data = wd;
    end
  endtask

  function automatic mem_pkt_t mkPkt(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] f3, input logic [3:0] bm);
    mem_pkt_t p;
    p.addr   = a;
    p.wdata  = d;
    p.funct3 = f3;
    p.bmask  = bm;
    return p;
  endfunction

  task automatic driveFifo();
    if (fifoQ.size() > 0) begin
      fifo_out   = fifoQ[0];
      fifo_empty = 1'b0;
    end else begin
      fifo_out   = mkPkt($urandom, $urandom, 3'($urandom_range(0, 7)), 4'h0);
      fifo_empty = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle against the
  // model, then advance the model across the rising edge.
  task automatic applyStimulus(input bit r, input bit req, input bit busy, input bit resp);
    bit          drainable, storeWin, expRen, expGnt, v;
    mem_pkt_t    pkt;
    logic [3:0]  mk;
    logic [31:0] dt;
    rst       = r;
    ld_req    = req;
    ld_busy   = busy;
    dmem_resp = resp;
    driveFifo();
    #3;
    drainable = (fifoQ.size() > 0) && (fifoQ[0].bmask == 4'h0);
    storeWin  = drainable && !busy && (!req || mStarve == 8);
    expRen    = !r && !mWriting && storeWin;
    expGnt    = !r && !mWriting && req && !storeWin;
    if (checkEn) begin
      checkOutput("fifo_ren", 32'(fifo_ren), 32'(expRen));
      checkOutput("ld_gnt", 32'(ld_gnt), 32'(expGnt));
      checkOutput("dmem_st_sel", 32'(dmem_st_sel), 32'(mWriting));
      checkOutput("st_busy", 32'(st_busy), 32'(mWriting));
      checkOutput("dmem_addr", dmem_addr, mWriting ? mAddr : 32'h0);
      checkOutput("dmem_wmask", 32'(dmem_wmask), mWriting ? 32'(mMask) : 32'h0);
      checkOutput("dmem_wdata", dmem_wdata, mWriting ? mData : 32'h0);
    end
    if (ld_gnt === 1'b1) obsGnt++;
    if (fifo_ren === 1'b1) obsRen = 1'b1;
    @(posedge clk);
    if (r) begin
      mWriting   = 1'b0;
      mStarve    = 0;
      mPerfSt    = 0;
      mPerfStall = 0;
    end else if (!mWriting) begin
      if (drainable && !storeWin) mPerfStall++;
      if (!drainable || storeWin) mStarve = 0;
      else if (req && mStarve < 8) mStarve++;
      if (storeWin) begin
        pkt = fifoQ.pop_front();
        refAlign(pkt.funct3, pkt.addr, pkt.wdata, v, mk, dt);
        if (v) begin
          mWriting = 1'b1;
          mAddr    = pkt.addr & 32'hFFFF_FFFC;
          mMask    = mk;
          mData    = dt;
        end
      end
    end else begin
      if (!drainable) mStarve = 0;
      if (resp) begin
        mWriting = 1'b0;
        mPerfSt++;
      end
    end
    #1;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    mem_pkt_t p;
    bit       reqHeavy;
    mWriting   = 1'b0;
    mStarve    = 0;
    mPerfSt    = 0;
    mPerfStall = 0;
    mAddr      = '0;
    mData      = '0;
    mMask      = '0;
    checkEn    = 1'b0;
    reqHeavy   = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);

    fifoQ.push_back(mkPkt(32'h1000_0006, 32'hDEAD_BEEF, 3'b010, 4'h0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_addr", dmem_addr, 32'h1000_0004);
    checkOutput("t1_wmask", 32'(dmem_wmask), 32'hF);
    checkOutput("t1_wdata", dmem_wdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    fifoQ.push_back(mkPkt(32'h2000_0003, 32'h0000_00A5, 3'b000, 4'h0));
    fifoQ.push_back(mkPkt(32'h2000_0002, 32'h1234_BEEF, 3'b001, 4'h0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_sb_wmask", 32'(dmem_wmask), 32'h8);
    checkOutput("t2_sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_sh_wmask", 32'(dmem_wmask), 32'hC);
    checkOutput("t2_sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    applyStimulus(0, 0, 0, 1);

    fifoQ.push_back(mkPkt(32'h3000_0000, 32'h0BAD_F00D, 3'b010, 4'b0010));
    repeat (3) applyStimulus(0, 0, 0, 0);
    fifoQ[0].bmask = 4'h0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("t3_busy", 32'(st_busy), 32'h1);
    applyStimulus(0, 0, 0, 1);

    fifoQ.push_back(mkPkt(32'h4000_0008, 32'h1111_2222, 3'b010, 4'h0));
    obsGnt = 0;
    obsRen = 1'b0;
    for (int i = 0; i < 20 && !obsRen; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("t4_gnt_cycles", 32'(obsGnt), 32'd8);
    checkOutput("t4_popped", 32'(obsRen), 32'h1);
    repeat (3) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);

    fifoQ.push_back(mkPkt(32'h5000_0010, 32'hCAFE_0001, 3'b010, 4'h0));
    fifoQ.push_back(mkPkt(32'h5000_0021, 32'hCAFE_0002, 3'b000, 4'h0));
    applyStimulus(0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_second_addr", dmem_addr, 32'h5000_0020);
    applyStimulus(0, 0, 0, 1);

    fifoQ.push_back(mkPkt(32'h6000_0004, 32'h7777_7777, 3'b010, 4'h0));
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_rst_busy", 32'(st_busy), 32'h0);
    checkOutput("t6_rst_addr", dmem_addr, 32'h0);
    fifoQ.push_back(mkPkt(32'h6000_0008, 32'h1234_5678, 3'b011, 4'h0));
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_undef_busy", 32'(st_busy), 32'h0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 60 == 0) reqHeavy = ($urandom_range(0, 1) == 1);
      if (fifoQ.size() < 4 && $urandom_range(0, 2) == 0) begin
        p = mkPkt($urandom, $urandom,
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        fifoQ.push_back(p);
      end
      if (fifoQ.size() > 0 && fifoQ[0].bmask != 4'h0 && $urandom_range(0, 2) == 0)
        fifoQ[0].bmask = 4'h0;
      applyStimulus($urandom_range(0, 199) == 0,
                    reqHeavy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 3) == 0,
                    mWriting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
    end

`ifdef POST_ST_DRAIN_PERF_EN
    checkOutput("perf_st_cnt", perf_st_cnt, 32'(mPerfSt));
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'(mPerfStall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
